// File: rtl/demux1to4_stream_pkg.sv
// Shared defaults and helpers for the 1-to-N stream demultiplexer.
package demux1to4_stream_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_NUM_CH = 4;
    localparam int DEF_SEL_W  = 2;

    // Bit offset of channel k inside the flattened out_data bus.
    function automatic int chan_slice(input int k, input int data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry holding register with load / valid / ready for one output channel.
// A load in the same cycle as a drain wins, which gives bubble-free pass-through.
module demux_chan_reg
    import demux1to4_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid
);

    logic [DATA_W-1:0] data_p1;
    logic              vld_p1;

    // Stage p1: capture a new beat, otherwise clear valid once the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (load) begin
            data_p1 <= load_data;
            vld_p1  <= 1'b1;
        end else if (vld_p1 && ready) begin
            vld_p1  <= 1'b0;
        end
    end

    assign data  = data_p1;
    assign valid = vld_p1;

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-NUM_CH stream demultiplexer. The destination comes from in_sel
// or from a round-robin slot counter; an out-of-range destination is consumed
// and reported with a one-cycle drop pulse.
module demux1to4_stream
    import demux1to4_stream_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int SEL_W  = DEF_SEL_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     auto_rr,
    input  logic                     slot_clr,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [SEL_W-1:0]         slot,
    output logic                     drop_pulse
);

    logic [SEL_W-1:0]  dest;
    logic [SEL_W-1:0]  slot_p1;
    logic              drop_p1;
    logic              in_range;
    logic              sel_rdy;
    logic              acc;
    logic [NUM_CH-1:0] load;

    // Destination select: slot counter in TDM mode, in_sel otherwise.
    always_comb begin
        dest = auto_rr ? slot_p1 : in_sel;
    end

    // Ready mux: the addressed channel must be empty or draining; unmatched
    // (out-of-range) destinations are always ready so the beat can be dropped.
    always_comb begin
        in_range = 1'b0;
        sel_rdy  = 1'b1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (dest == SEL_W'(k)) begin
                in_range = 1'b1;
                sel_rdy  = ~out_valid[k] | out_ready[k];
            end
        end
    end

    assign in_ready = sel_rdy;
    assign acc      = in_valid & sel_rdy;

    // One-hot load strobe toward the addressed channel register.
    always_comb begin
        load = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            load[k] = acc & (dest == SEL_W'(k));
        end
    end

    // Stage p1: slot counter; clear wins over advance, wrap keeps it in range.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_p1 <= '0;
        end else if (slot_clr) begin
            slot_p1 <= '0;
        end else if (auto_rr && acc) begin
            slot_p1 <= (slot_p1 == SEL_W'(NUM_CH - 1)) ? '0 : slot_p1 + 1'b1;
        end
    end

    // Stage p1: flag a consumed beat that had no channel to land in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_p1 <= 1'b0;
        end else begin
            drop_p1 <= acc & ~in_range;
        end
    end

    assign slot       = slot_p1;
    assign drop_pulse = drop_p1;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        demux_chan_reg #(
            .DATA_W (DATA_W)
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (load[k]),
            .load_data (in_data),
            .ready     (out_ready[k]),
            .data      (out_data[chan_slice(k, DATA_W) +: DATA_W]),
            .valid     (out_valid[k])
        );
    end

endmodule

// File: tb/tb_demux1to4_stream.sv
// Scoreboard bench for demux1to4_stream: stimulus pushes hand-computed expected
// beats per channel; a negedge monitor pops and compares on every output handshake.
module tb_demux1to4_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = '0;
    logic [1:0]  in_sel = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        auto_rr = 1'b0;
    logic        slot_clr = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready = 4'b1111;
    logic [1:0]  slot;
    logic        drop_pulse;

    logic [7:0]  in3_data = '0;
    logic [1:0]  in3_sel = '0;
    logic        in3_valid = 1'b0;
    logic        in3_ready;
    logic [23:0] out3_data;
    logic [2:0]  out3_valid;
    logic [1:0]  slot3;
    logic        drop3;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[4][$];

    demux1to4_stream #(.DATA_W(8), .NUM_CH(4), .SEL_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .auto_rr(auto_rr),
        .slot_clr(slot_clr), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .slot(slot), .drop_pulse(drop_pulse)
    );

    demux1to4_stream #(.DATA_W(8), .NUM_CH(3), .SEL_W(2)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in3_data), .in_sel(in3_sel),
        .in_valid(in3_valid), .in_ready(in3_ready), .auto_rr(1'b0),
        .slot_clr(1'b0), .out_data(out3_data), .out_valid(out3_valid),
        .out_ready(3'b111), .slot(slot3), .drop_pulse(drop3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every handshake on a channel must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat ch%0d actual=%0h required=none", k, out_data[k*8 +: 8]);
                    end else begin
                        chk($sformatf("ch%0d_data", k), 32'(out_data[k*8 +: 8]), 32'(exp_q[k].pop_front()));
                    end
                end
            end
        end
    end

    // Present a beat (called at posedge+1), wait for acceptance, leave in_valid high.
    task automatic send(input logic [1:0] sel, input logic [7:0] d, input logic rr,
                        input logic clr, input int exp_ch);
        int cnt;
        in_sel = sel; in_data = d; auto_rr = rr; slot_clr = clr; in_valid = 1'b1;
        cnt = 0;
        #1;
        while (!in_ready && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 50) begin
            total++; bad++;
            $display("FAIL send_timeout actual=stalled required=accept data=%0h", d);
        end else begin
            exp_q[exp_ch].push_back(d);
        end
        @(posedge clk); #1;
        slot_clr = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        slot_clr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_slot", 32'(slot), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h1);
        chk("rst_drop", 32'(drop_pulse), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        @(posedge clk); #1;

        // Out-of-range drop on the 3-channel instance
        in3_sel = 2'd3; in3_data = 8'h7E; in3_valid = 1'b1;
        #1 chk("oor_in_ready", 32'(in3_ready), 32'h1);
        @(posedge clk); #1;
        in3_valid = 1'b0;
        chk("oor_drop_hi", 32'(drop3), 32'h1);
        chk("oor_no_valid", 32'(out3_valid), 32'h0);
        @(posedge clk); #1;
        chk("oor_drop_lo", 32'(drop3), 32'h0);
        chk("oor_no_valid2", 32'(out3_valid), 32'h0);

        // Select-mode routing
        send(2'd2, 8'hA5, 1'b0, 1'b0, 2);
        idle();
        chk("sel_out_valid", 32'(out_valid), 32'h4);
        chk("sel_ch2", 32'(out_data[23:16]), 32'hA5);
        chk("sel_others", 32'({out_data[31:24], out_data[15:0]}), 32'h0);
        @(posedge clk); #1;

        // Backpressure on ch1 with pass-through acceptance
        out_ready = 4'b1101;
        send(2'd1, 8'h11, 1'b0, 1'b0, 1);
        in_sel = 2'd1; in_data = 8'h22;
        #1 chk("bp_stall", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        chk("bp_stall2", 32'(in_ready), 32'h0);
        chk("bp_hold", 32'(out_data[15:8]), 32'h11);
        chk("bp_hold_vld", 32'(out_valid[1]), 32'h1);
        out_ready = 4'b1111;
        #1 chk("bp_pass_rdy", 32'(in_ready), 32'h1);
        exp_q[1].push_back(8'h22);
        @(posedge clk); #1;
        idle();
        chk("bp_new_vld", 32'(out_valid[1]), 32'h1);
        chk("bp_new_data", 32'(out_data[15:8]), 32'h22);
        @(posedge clk); #1;

        // TDM round-robin, back to back
        chk("tdm_start_slot", 32'(slot), 32'h0);
        send(2'd3, 8'h01, 1'b1, 1'b0, 0);
        send(2'd3, 8'h02, 1'b1, 1'b0, 1);
        send(2'd3, 8'h03, 1'b1, 1'b0, 2);
        send(2'd3, 8'h04, 1'b1, 1'b0, 3);
        chk("tdm_wrap_slot", 32'(slot), 32'h0);
        send(2'd3, 8'h05, 1'b1, 1'b0, 0);
        send(2'd3, 8'h06, 1'b1, 1'b0, 1);
        chk("tdm_end_slot", 32'(slot), 32'h2);

        // Slot clear wins over advance
        send(2'd0, 8'h07, 1'b1, 1'b0, 2);
        chk("clr_pre_slot", 32'(slot), 32'h3);
        send(2'd0, 8'h08, 1'b1, 1'b1, 3);
        idle();
        chk("clr_slot", 32'(slot), 32'h0);
        chk("clr_ch3_vld", 32'(out_valid), 32'h8);
        @(posedge clk); #1;

        // Async reset mid-stream
        auto_rr = 1'b0;
        out_ready = 4'b1010;
        send(2'd0, 8'h30, 1'b0, 1'b0, 0);
        send(2'd2, 8'h32, 1'b0, 1'b0, 2);
        idle();
        chk("ar_held", 32'(out_valid), 32'h5);
        #2 rst_n = 1'b0;
        #1 chk("ar_async_clear", 32'(out_valid), 32'h0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        @(negedge clk); #2 rst_n = 1'b1;
        out_ready = 4'b1111;
        @(posedge clk); #1;
        chk("ar_slot", 32'(slot), 32'h0);
        send(2'd0, 8'h40, 1'b0, 1'b0, 0);
        idle();
        chk("ar_first_vld", 32'(out_valid), 32'h1);
        chk("ar_first_data", 32'(out_data[7:0]), 32'h40);

        // Drain and confirm every expected beat was delivered
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) chk($sformatf("drain_ch%0d", k), 32'(exp_q[k].size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
